// File: rtl/axi_read_scheduler.sv
// axi_read_scheduler: shares one AXI read port (AR/R) between N read masters.
// One burst is outstanding at a time. Arbitration is fixed priority: starved
// masters first, then PRIO_MASTER, then the lowest valid index. R beats are
// steered back to the granted master combinationally.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid/req_addr/req_len       per-master burst requests (sliced buses)
//   req_ready                        pulse on the AR handshake of that master
//   ARVALID/ARREADY/ARID/ARLEN/ARADDR  AXI read-address channel
//   RVALID/RLAST/RID/RDATA/RREADY      AXI read-data channel
//   resp_valid/resp_last/resp_data   per-master beat strobes, shared data
//   busy                             scheduler not idle
//   proto_err                        sticky protocol-error flag
module axi_read_scheduler #(
  parameter int unsigned N_MASTERS    = 3,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned PRIO_MASTER  = 1,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [N_MASTERS-1:0]            req_valid,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_MASTERS*4-1:0]          req_len,
  output logic [N_MASTERS-1:0]            req_ready,
  output logic                            ARVALID,
  input  logic                            ARREADY,
  output logic [3:0]                      ARID,
  output logic [3:0]                      ARLEN,
  output logic [ADDR_WIDTH-1:0]           ARADDR,
  input  logic                            RVALID,
  input  logic                            RLAST,
  input  logic [3:0]                      RID,
  input  logic [DATA_WIDTH-1:0]           RDATA,
  output logic                            RREADY,
  output logic [N_MASTERS-1:0]            resp_valid,
  output logic [N_MASTERS-1:0]            resp_last,
  output logic [DATA_WIDTH-1:0]           resp_data,
  output logic                            busy,
  output logic                            proto_err
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

  state_e                  state_q;
  logic                    arvalid_q;
  logic [3:0]              arid_q;
  logic [3:0]              arlen_q;
  logic [ADDR_WIDTH-1:0]   araddr_q;
  logic [3:0]              beat_q;
  logic                    rready_q;
  logic                    err_q;
  logic [CNT_W-1:0]        wait_q [N_MASTERS];

  logic [3:0]              grant_d;
  logic                    found;
  logic [ADDR_WIDTH-1:0]   sel_addr_d;
  logic [3:0]              sel_len_d;

  // Grant: starved (lowest index) > preferred master > lowest valid index.
  always_comb begin
    grant_d = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!found && req_valid[i] && wait_q[i] == LIMIT) begin
        grant_d = 4'(i);
        found   = 1'b1;
      end
    end
    if (!found && req_valid[PRIO_MASTER]) begin
      grant_d = 4'(PRIO_MASTER);
      found   = 1'b1;
    end
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (!found && req_valid[i]) begin
        grant_d = 4'(i);
        found   = 1'b1;
      end
    end
  end

  // Address/length of the granted master.
  always_comb begin
    sel_addr_d = '0;
    sel_len_d  = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (grant_d == 4'(i)) begin
        sel_addr_d = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len_d  = req_len[i*4 +: 4];
      end
    end
  end

  // FSM, AR registers, beat counter, starvation counters, error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      arid_q    <= '0;
      arlen_q   <= '0;
      araddr_q  <= '0;
      beat_q    <= '0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
      for (int unsigned i = 0; i < N_MASTERS; i++) wait_q[i] <= '0;
    end else begin
      rready_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (RVALID && rready_q) err_q <= 1'b1;
          if (|req_valid) begin
            state_q   <= S_ADDR;
            arvalid_q <= 1'b1;
            arid_q    <= grant_d;
            arlen_q   <= sel_len_d;
            araddr_q  <= sel_addr_d;
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
              if (grant_d == 4'(i)) wait_q[i] <= '0;
              else if (req_valid[i] && wait_q[i] != LIMIT) wait_q[i] <= wait_q[i] + CNT_W'(1);
            end
          end
        end
        S_ADDR: begin
          if (RVALID && rready_q) err_q <= 1'b1;
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            beat_q    <= '0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (RVALID) begin
            // Foreign-ID beats are drained without counting.
            if (RID != arid_q) begin
              err_q <= 1'b1;
            end else if (RLAST) begin
              if (beat_q != arlen_q) err_q <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              if (beat_q == arlen_q) err_q <= 1'b1;
              beat_q <= beat_q + 4'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Beat steering and AR handshake pulse; gated by reset so an aborted burst emits nothing.
  always_comb begin
    resp_valid = '0;
    resp_last  = '0;
    req_ready  = '0;
    for (int unsigned i = 0; i < N_MASTERS; i++) begin
      if (rst_n && state_q == S_DATA && RVALID && RID == arid_q && arid_q == 4'(i)) begin
        resp_valid[i] = 1'b1;
        resp_last[i]  = RLAST;
      end
      if (rst_n && state_q == S_ADDR && ARREADY && arid_q == 4'(i)) req_ready[i] = 1'b1;
    end
  end

  assign ARVALID   = arvalid_q;
  assign ARID      = arid_q;
  assign ARLEN     = arlen_q;
  assign ARADDR    = araddr_q;
  assign RREADY    = rready_q;
  assign resp_data = RDATA;
  assign busy      = (state_q != S_IDLE);
  assign proto_err = err_q;

endmodule

// File: tb/tb_axi_read_scheduler.sv
// Randomized scoreboard bench for axi_read_scheduler with a transaction-level reference model.
module tb_axi_read_scheduler;

  localparam int unsigned NM = 3;
  localparam int unsigned AW = 26;
  localparam int unsigned DW = 32;
  localparam int SL = 15;
  localparam int P_IDLE = 0;
  localparam int P_ADDR = 1;
  localparam int P_DATA = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     req_valid;
  logic [NM*AW-1:0]  req_addr;
  logic [NM*4-1:0]   req_len;
  logic [NM-1:0]     req_ready;
  logic              ARVALID, ARREADY;
  logic [3:0]        ARID, ARLEN;
  logic [AW-1:0]     ARADDR;
  logic              RVALID, RLAST, RREADY;
  logic [3:0]        RID;
  logic [DW-1:0]     RDATA;
  logic [NM-1:0]     resp_valid, resp_last;
  logic [DW-1:0]     resp_data;
  logic              busy, proto_err;

  always #5 clk = ~clk;

  axi_read_scheduler #(
    .N_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIO_MASTER(1), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
    .RVALID(RVALID), .RLAST(RLAST), .RID(RID), .RDATA(RDATA), .RREADY(RREADY),
    .resp_valid(resp_valid), .resp_last(resp_last), .resp_data(resp_data),
    .busy(busy), .proto_err(proto_err)
  );

  typedef struct {int id; logic [3:0] len; logic [AW-1:0] addr;} ar_t;
  typedef struct {int id; logic [DW-1:0] data; bit last;} bt_t;

  int tests = 0;
  int fails = 0;

  // Reference model: state after the next clock edge (m_*) and in the current cycle (now_*).
  int m_phase, m_g, m_beat;
  logic [3:0] m_len;
  int m_wait [NM];
  bit m_err;
  int now_phase, now_g;
  bit now_err;
  int hs;
  int budget [NM];
  int p_req, p_ar, p_r;
  bit use_fix, inj_badid, inj_early, mon_en;
  logic [AW-1:0] fix_addr;
  logic [3:0] fix_len;
  ar_t exp_ar[$];
  bt_t exp_bt[$];
  int obs_ids[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NM-1:0] v);
    for (int i = 0; i < NM; i++) if (v[i] && m_wait[i] == SL) return i;
    if (v[1]) return 1;
    for (int i = 0; i < NM; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_g = 0; m_beat = 0; m_len = '0; m_err = 1'b0;
    now_phase = P_IDLE; now_g = 0; now_err = 1'b0; hs = -1;
    for (int i = 0; i < NM; i++) begin m_wait[i] = 0; budget[i] = 0; end
    exp_ar.delete(); exp_bt.delete();
    inj_badid = 1'b0; inj_early = 1'b0;
  endtask

  // Drives inputs for the coming edge and advances the model across it.
  task automatic drive();
    int g;
    now_phase = m_phase; now_g = m_g; now_err = m_err;
    if (hs >= 0) begin req_valid[hs] = 1'b0; hs = -1; end
    for (int i = 0; i < NM; i++) begin
      if (!req_valid[i] && budget[i] > 0 && $urandom_range(0, 99) < p_req) begin
        budget[i]--;
        req_valid[i] = 1'b1;
        req_addr[i*AW +: AW] = use_fix ? fix_addr : AW'($urandom);
        req_len[i*4 +: 4]    = use_fix ? fix_len : 4'($urandom_range(0, 3));
      end
    end
    ARREADY = ($urandom_range(0, 99) < p_ar);
    RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = $urandom;
    case (m_phase)
      P_IDLE: if (req_valid != '0) begin
        g = pick(req_valid);
        for (int i = 0; i < NM; i++) begin
          if (i == g) m_wait[i] = 0;
          else if (req_valid[i] && m_wait[i] < SL) m_wait[i]++;
        end
        exp_ar.push_back('{id: g, len: req_len[g*4 +: 4], addr: req_addr[g*AW +: AW]});
        m_g = g; m_len = req_len[g*4 +: 4]; m_phase = P_ADDR;
      end
      P_ADDR: if (ARREADY) begin hs = m_g; m_phase = P_DATA; m_beat = 0; end
      default: if ($urandom_range(0, 99) < p_r) begin
        RVALID = 1'b1;
        if (inj_badid) begin
          inj_badid = 1'b0;
          RID = (m_g == 2) ? 4'd0 : 4'd2;
          RLAST = 1'($urandom);
          m_err = 1'b1;
        end else begin
          RID = 4'(m_g);
          RLAST = (m_beat == int'(m_len)) || (inj_early && m_beat == 2);
          exp_bt.push_back('{id: m_g, data: RDATA, last: RLAST});
          if (RLAST) begin
            inj_early = 1'b0;
            if (m_beat != int'(m_len)) m_err = 1'b1;
            m_phase = P_IDLE;
          end else begin
            if (m_beat == int'(m_len)) m_err = 1'b1;
            m_beat++;
          end
        end
      end
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin drive(); @(posedge clk); #1; end
  endtask

  task automatic do_reset(input bit beat_in_reset);
    int g;
    g = m_g;
    mon_en = 1'b0;
    rst_n = 1'b0;
    req_valid = '0; ARREADY = 1'b1; RLAST = 1'b0; RDATA = 32'hDEAD_BEEF;
    RVALID = beat_in_reset; RID = 4'(g);
    model_reset();
    @(negedge clk);
    chk("rst_resp_valid_gate", 64'(resp_valid), 64'(0));
    chk("rst_req_ready_gate", 64'(req_ready), 64'(0));
    @(posedge clk); #1;
    RVALID = 1'b0;
    chk("rst_arvalid", 64'(ARVALID), 64'(0));
    chk("rst_arid", 64'(ARID), 64'(0));
    chk("rst_arlen", 64'(ARLEN), 64'(0));
    chk("rst_araddr", 64'(ARADDR), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_last", 64'(resp_last), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_proto_err", 64'(proto_err), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
  endtask

  // Monitor: compares each cycle's outputs with the model and pops the scoreboards.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("busy", 64'(busy), 64'(now_phase != P_IDLE));
      chk("proto_err", 64'(proto_err), 64'(now_err));
      chk("rready", 64'(RREADY), 64'(1));
      chk("arvalid", 64'(ARVALID), 64'(now_phase == P_ADDR));
      chk("req_ready", 64'(req_ready),
          (now_phase == P_ADDR && ARREADY) ? 64'(1) << now_g : 64'(0));
      if (ARVALID) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", 64'(ARVALID), 64'(0));
        else begin
          chk("arid", 64'(ARID), 64'(exp_ar[0].id));
          chk("arlen", 64'(ARLEN), 64'(exp_ar[0].len));
          chk("araddr", 64'(ARADDR), 64'(exp_ar[0].addr));
          if (ARREADY) begin
            obs_ids.push_back(int'(ARID));
            void'(exp_ar.pop_front());
          end
        end
      end
      if (resp_valid != '0) begin
        if (exp_bt.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
        else begin
          chk("resp_valid", 64'(resp_valid), 64'(1) << exp_bt[0].id);
          chk("resp_last", 64'(resp_last), exp_bt[0].last ? 64'(1) << exp_bt[0].id : 64'(0));
          chk("resp_data", 64'(resp_data), 64'(exp_bt[0].data));
          void'(exp_bt.pop_front());
        end
      end else begin
        chk("resp_last_idle", 64'(resp_last), 64'(0));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    req_valid = '0; req_addr = '0; req_len = '0;
    ARREADY = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RID = '0; RDATA = '0;
    p_req = 100; p_ar = 100; p_r = 100; use_fix = 1'b0; fix_addr = '0; fix_len = '0;
    mon_en = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_reset(1'b0);

    // Single request: master 0, addr 0x100, len 3.
    use_fix = 1'b1; fix_addr = 26'h100; fix_len = 4'd3;
    budget[0] = 1;
    b = obs_ids.size();
    run(10);
    chk("single_grants", 64'(obs_ids.size() - b), 64'(1));
    if (obs_ids.size() > b) chk("single_id", 64'(obs_ids[b]), 64'(0));
    chk("single_bt_drained", 64'(exp_bt.size()), 64'(0));

    // Priority: all three request together, expected order 1, 0, 2.
    fix_len = 4'd1;
    budget[0] = 1; budget[1] = 1; budget[2] = 1;
    b = obs_ids.size();
    run(20);
    chk("prio_grants", 64'(obs_ids.size() - b), 64'(3));
    if (obs_ids.size() >= b + 3) begin
      chk("prio_0", 64'(obs_ids[b]), 64'(1));
      chk("prio_1", 64'(obs_ids[b+1]), 64'(0));
      chk("prio_2", 64'(obs_ids[b+2]), 64'(2));
    end

    // ARREADY held low for 5 cycles.
    fix_len = 4'd0; budget[2] = 1; p_ar = 0;
    run(6);
    chk("arready_low_arvalid", 64'(ARVALID), 64'(1));
    p_ar = 100;
    run(6);

    // Protocol errors: foreign-ID beat, then early RLAST on a len-3 burst.
    fix_len = 4'd3; budget[0] = 1; inj_badid = 1'b1;
    run(12);
    budget[0] = 1; inj_early = 1'b1;
    run(12);
    chk("proto_sticky", 64'(proto_err), 64'(1));
    chk("proto_idle", 64'(busy), 64'(0));
    chk("proto_bt_drained", 64'(exp_bt.size()), 64'(0));
    do_reset(1'b0);

    // Starvation: masters 1 and 2 request back-to-back with len 0.
    fix_len = 4'd0; budget[1] = 20; budget[2] = 3;
    b = obs_ids.size();
    run(150);
    chk("starve_grants", 64'(obs_ids.size() - b >= 17), 64'(1));
    if (obs_ids.size() >= b + 17) begin
      for (int k = 0; k < 15; k++) chk("starve_prio", 64'(obs_ids[b+k]), 64'(1));
      chk("starve_win", 64'(obs_ids[b+15]), 64'(2));
      chk("starve_after", 64'(obs_ids[b+16]), 64'(1));
    end

    // Mid-burst reset after the first beat, then a normal request.
    fix_len = 4'd3; budget[0] = 1;
    for (int k = 0; k < 20 && !(m_phase == P_DATA && m_beat >= 1); k++) run(1);
    chk("midreset_bt_drained", 64'(exp_bt.size()), 64'(0));
    do_reset(1'b1);
    budget[2] = 1; fix_len = 4'd1;
    b = obs_ids.size();
    run(10);
    chk("post_reset_grant", 64'(obs_ids.size() - b), 64'(1));

    // Randomized traffic, then drain.
    use_fix = 1'b0; p_req = 30; p_ar = 60; p_r = 70;
    for (int i = 0; i < NM; i++) budget[i] = 150;
    run(2000);
    for (int i = 0; i < NM; i++) budget[i] = 0;
    p_ar = 100; p_r = 100;
    run(100);
    chk("final_ar_drained", 64'(exp_ar.size()), 64'(0));
    chk("final_bt_drained", 64'(exp_bt.size()), 64'(0));
    chk("final_idle", 64'(busy), 64'(0));

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
